// File: rtl/led_seq_pkg.sv
// led_seq_pkg: register offsets, mode encodings and
// CTRL/STATUS field positions for the LED sequencer.
package led_seq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTL   = 2'd2,
        MODE_ROTR   = 2'd3
    } mode_e;

    localparam int CTRL_MODE_LSB   = 0;
    localparam int CTRL_EN_BIT     = 2;
    localparam int CTRL_IRQ_EN_BIT = 3;

    localparam int ST_PEND_BIT = 0;
    localparam int ST_STEP_LSB = 8;
    localparam int ST_LED_LSB  = 16;

endpackage

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: step-rate counter. tick pulses when count
// reaches period-1 while enabled with a nonzero period.
// Ports: clk, reset (sync, high), clr, en, period -> tick.
module led_seq_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic             run;

    assign run  = en && (period != '0);
    assign tick = run && (count == period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: memory-mapped LED sequencer (static, blink,
// rotl, rotr) with step-wrap interrupt.
// Ports: clk, reset (sync, high); bus_we/bus_addr/bus_wdata
// write port, bus_rdata combinational readback; led_we and
// led_wdata registered LED writes; led_rdata LED readback;
// irq = pending & irq_en.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        led_we,
    output logic [31:0] led_wdata,
    input  logic [31:0] led_rdata,
    output logic        irq
);

    mode_e              mode;
    logic               en;
    logic               irq_en;
    logic [31:0]        pattern;
    logic [CNT_W-1:0]   period;
    logic               pending;
    logic [STEP_W-1:0]  step;
    logic [31:0]        work;
    logic               phase;

    logic  wr_ctrl, wr_pat, wr_per, wr_stat;
    mode_e new_mode;
    logic  new_en;
    logic  en_rise, mode_chg;
    logic  tick_raw, tick_ev, step_ev, wrap;
    logic  pre_clr;
    logic  unused;

    assign wr_ctrl = bus_we && (bus_addr == ADDR_CTRL);
    assign wr_pat  = bus_we && (bus_addr == ADDR_PATTERN);
    assign wr_per  = bus_we && (bus_addr == ADDR_PERIOD);
    assign wr_stat = bus_we && (bus_addr == ADDR_STATUS);

    assign new_mode = mode_e'(bus_wdata[CTRL_MODE_LSB +: 2]);
    assign new_en   = bus_wdata[CTRL_EN_BIT];
    assign en_rise  = wr_ctrl && !en && new_en;
    assign mode_chg = wr_ctrl && (new_mode != mode);

    // Any bus write swallows a coincident tick and restarts the period.
    assign tick_ev = tick_raw && !bus_we;
    assign pre_clr = wr_pat || wr_per || en_rise
                  || (bus_we && tick_raw);

    assign step_ev = tick_ev && (mode != MODE_STATIC);
    assign wrap    = step_ev && (step == '1);

    assign irq    = pending && irq_en;
    assign unused = ^led_rdata[31:16];

    led_seq_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr    (pre_clr),
        .en     (en),
        .period (period),
        .tick   (tick_raw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= MODE_STATIC;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            pattern   <= '0;
            period    <= '0;
            pending   <= 1'b0;
            step      <= '0;
            work      <= '0;
            phase     <= 1'b0;
            led_we    <= 1'b0;
            led_wdata <= '0;
        end else begin
            led_we <= 1'b0;

            if (wr_ctrl) begin
                mode   <= new_mode;
                en     <= new_en;
                irq_en <= bus_wdata[CTRL_IRQ_EN_BIT];
                if (mode_chg) begin
                    phase <= 1'b0;
                    step  <= '0;
                end
                if (en_rise) begin
                    led_we    <= 1'b1;
                    led_wdata <= work;
                end
            end

            if (wr_pat) begin
                pattern <= bus_wdata;
                work    <= bus_wdata;
                phase   <= 1'b0;
                step    <= '0;
                if (en) begin
                    led_we    <= 1'b1;
                    led_wdata <= bus_wdata;
                end
            end

            if (wr_per) begin
                period <= bus_wdata[CNT_W-1:0];
            end

            if (step_ev) begin
                step   <= step + STEP_W'(1);
                led_we <= 1'b1;
                unique case (mode)
                    MODE_BLINK: begin
                        phase     <= !phase;
                        led_wdata <= phase ? '0 : work;
                    end
                    MODE_ROTL: begin
                        work      <= {work[30:0], work[31]};
                        led_wdata <= {work[30:0], work[31]};
                    end
                    MODE_ROTR: begin
                        work      <= {work[0], work[31:1]};
                        led_wdata <= {work[0], work[31:1]};
                    end
                    default: ;
                endcase
            end

            // A wrap on the same edge as a W1C keeps pending set.
            if (wrap) begin
                pending <= 1'b1;
            end else if (wr_stat && bus_wdata[ST_PEND_BIT]) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        bus_rdata = '0;
        unique case (bus_addr)
            ADDR_CTRL: begin
                bus_rdata[CTRL_MODE_LSB +: 2] = mode;
                bus_rdata[CTRL_EN_BIT]        = en;
                bus_rdata[CTRL_IRQ_EN_BIT]    = irq_en;
            end
            ADDR_PATTERN: bus_rdata = pattern;
            ADDR_PERIOD:  bus_rdata = 32'(period);
            ADDR_STATUS: begin
                bus_rdata[ST_PEND_BIT]           = pending;
                bus_rdata[ST_STEP_LSB +: STEP_W] = step;
                bus_rdata[ST_LED_LSB +: 16]      = led_rdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed scenarios plus a randomized run
// compared against a spec-level model of the sequencer.
`timescale 1ns/1ps
module tb_led_seq_ctrl;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_PAT  = 2'd1;
    localparam logic [1:0] A_PER  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        led_we;
    logic [31:0] led_wdata;
    logic [31:0] led_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .led_we    (led_we),
        .led_wdata (led_wdata),
        .led_rdata (led_rdata),
        .irq       (irq)
    );

    // Reference model state
    logic [1:0]  m_mode;
    logic        m_en, m_ien, m_pend, m_phase, m_we;
    logic [31:0] m_pat, m_per, m_work, m_wd;
    longint      m_cnt;
    int          m_step;

    always @(posedge clk) begin : model_blk
        logic        tk, rise, clr;
        logic [1:0]  mode;
        logic        en, ien, pend, phase, we;
        logic [31:0] pat, per, work, wd;
        longint      cnt;
        int          step;
        mode = m_mode; en = m_en; ien = m_ien; pend = m_pend;
        phase = m_phase; pat = m_pat; per = m_per;
        work = m_work; wd = m_wd; cnt = m_cnt; step = m_step;
        we = 1'b0;
        tk = m_en && (m_per != 0) && (m_cnt + 1 == longint'(m_per));
        rise = bus_we && bus_addr == A_CTRL && !m_en && bus_wdata[2];
        clr = bus_we && (tk || bus_addr == A_PAT
                         || bus_addr == A_PER || rise);
        if (clr || tk) cnt = 0;
        else if (m_en && m_per != 0) cnt = cnt + 1;
        if (bus_we) begin
            case (bus_addr)
                A_CTRL: begin
                    if (bus_wdata[1:0] != m_mode) begin
                        phase = 1'b0;
                        step = 0;
                    end
                    mode = bus_wdata[1:0];
                    en = bus_wdata[2];
                    ien = bus_wdata[3];
                    if (rise) begin we = 1'b1; wd = m_work; end
                end
                A_PAT: begin
                    pat = bus_wdata; work = bus_wdata;
                    phase = 1'b0; step = 0;
                    if (m_en) begin we = 1'b1; wd = bus_wdata; end
                end
                A_PER: per = bus_wdata;
                default: if (bus_wdata[0]) pend = 1'b0;
            endcase
        end else if (tk && m_mode != 2'd0) begin
            case (m_mode)
                2'd1: begin
                    phase = !m_phase;
                    wd = phase ? m_work : 32'd0;
                end
                2'd2: begin
                    work = (m_work << 1) | (m_work >> 31);
                    wd = work;
                end
                default: begin
                    work = (m_work >> 1) | (m_work << 31);
                    wd = work;
                end
            endcase
            we = 1'b1;
            step = (m_step + 1) % 32;
            if (step == 0) pend = 1'b1;
        end
        if (reset) begin
            mode = 0; en = 0; ien = 0; pend = 0; phase = 0;
            pat = 0; per = 0; work = 0; wd = 0; cnt = 0;
            step = 0; we = 0;
        end
        m_mode <= mode; m_en <= en; m_ien <= ien; m_pend <= pend;
        m_phase <= phase; m_pat <= pat; m_per <= per;
        m_work <= work; m_wd <= wd; m_cnt <= cnt;
        m_step <= step; m_we <= we;
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            A_CTRL:  return {28'd0, m_ien, m_en, m_mode};
            A_PAT:   return m_pat;
            A_PER:   return m_per;
            default: return {led_rdata[15:0], 3'd0, 5'(m_step),
                             7'd0, m_pend};
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_we = 1'b1;
        bus_addr = a;
        bus_wdata = d;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (led_we !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: led_we=%b irq=%b, need 0 0",
                         i, led_we, irq);
            end
        end
        checks++;
        if (led_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_wdata: got %h need 0", led_wdata);
        end
        for (int a = 0; a < 4; a++) begin
            bus_addr = 2'(a);
            led_rdata = $urandom;
            #1;
            exp = (a == 3) ? {led_rdata[15:0], 16'h0} : 32'd0;
            checks++;
            if (bus_rdata !== exp) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h need %h",
                         a, bus_rdata, exp);
            end
        end
    endtask

    task automatic test_static();
        int bad;
        bus_write(A_CTRL, 32'h4);
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'd0) begin
            errors++;
            $display("FAIL static_en: we=%b wd=%h need 1 0", led_we, led_wdata);
        end
        bus_write(A_PAT, 32'hA5A5A5A5);
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL static_pat: we=%b wd=%h need 1 a5a5a5a5",
                     led_we, led_wdata);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (led_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || led_wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL static_quiet: %0d writes wd=%h need 0 a5a5a5a5",
                     bad, led_wdata);
        end
    endtask

    task automatic test_rotl();
        logic [31:0] exp [3];
        exp[0] = 32'h3; exp[1] = 32'h6; exp[2] = 32'hC;
        bus_write(A_CTRL, 32'h0);
        checks++;
        if (led_we !== 1'b0) begin
            errors++;
            $display("FAIL en_off: led_we=%b need 0", led_we);
        end
        bus_write(A_PER, 32'd4);
        bus_write(A_PAT, 32'h80000001);
        bus_write(A_CTRL, 32'h6);
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'h80000001) begin
            errors++;
            $display("FAIL rotl_start: we=%b wd=%h need 1 80000001",
                     led_we, led_wdata);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                checks++;
                if (i < 4 && led_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rotl_gap step %0d cyc %0d: we=%b need 0",
                             k, i, led_we);
                end else if (i == 4 && (led_we !== 1'b1
                             || led_wdata !== exp[k])) begin
                    errors++;
                    $display("FAIL rotl_step %0d: we=%b wd=%h need 1 %h",
                             k, led_we, led_wdata, exp[k]);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [31:0] exp [4];
        exp[0] = 32'hFF; exp[1] = 32'h0; exp[2] = 32'hFF; exp[3] = 32'h0;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PER, 32'd3);
        bus_write(A_PAT, 32'hFF);
        bus_write(A_CTRL, 32'h5);
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'hFF) begin
            errors++;
            $display("FAIL blink_start: we=%b wd=%h need 1 ff", led_we, led_wdata);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                checks++;
                if (i < 3 && led_we !== 1'b0) begin
                    errors++;
                    $display("FAIL blink_gap %0d: we=%b need 0", k, led_we);
                end else if (i == 3 && (led_we !== 1'b1
                             || led_wdata !== exp[k])) begin
                    errors++;
                    $display("FAIL blink_step %0d: we=%b wd=%h need 1 %h",
                             k, led_we, led_wdata, exp[k]);
                end
            end
        end
    endtask

    task automatic test_irq();
        int bad;
        logic [31:0] exp;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PAT, 32'h1);
        bus_write(A_PER, 32'd1);
        bus_write(A_CTRL, 32'hF);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (irq !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL irq_early: irq high %0d cycles, need 0", bad);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_wrap: irq=%b need 1", irq);
        end
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'h1) begin
            errors++;
            $display("FAIL rotr_32: we=%b wd=%h need 1 1", led_we, led_wdata);
        end
        bus_addr = A_STAT;
        led_rdata = $urandom;
        #1;
        exp = {led_rdata[15:0], 16'h0001};
        checks++;
        if (bus_rdata !== exp) begin
            errors++;
            $display("FAIL status_wrap: got %h need %h", bus_rdata, exp);
        end
        bus_write(A_STAT, 32'hFFFFFFFE);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_other_bits: irq=%b need 1", irq);
        end
        bus_write(A_STAT, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: irq=%b need 0", irq);
        end
    endtask

    task automatic test_collision();
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PER, 32'd5);
        bus_write(A_PAT, 32'h1);
        bus_write(A_CTRL, 32'h6);
        repeat (4) @(negedge clk);
        bus_write(A_PAT, 32'h12345678);
        checks++;
        if (led_we !== 1'b1 || led_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL collide_pat: we=%b wd=%h need 1 12345678",
                     led_we, led_wdata);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (i < 5 && led_we !== 1'b0) begin
                errors++;
                $display("FAIL collide_gap cyc %0d: we=%b need 0", i, led_we);
            end else if (i == 5 && (led_we !== 1'b1
                         || led_wdata !== 32'h2468ACF0)) begin
                errors++;
                $display("FAIL collide_next: we=%b wd=%h need 1 2468acf0",
                         led_we, led_wdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (led_we !== 1'b0 || irq !== 1'b0 || led_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: we=%b irq=%b wd=%h need 0 0 0",
                     led_we, irq, led_wdata);
        end
        for (int a = 0; a < 4; a++) begin
            bus_addr = 2'(a);
            #1;
            exp = (a == 3) ? {led_rdata[15:0], 16'h0} : 32'd0;
            checks++;
            if (bus_rdata !== exp) begin
                errors++;
                $display("FAIL reset_mid_read addr %0d: got %h need %h",
                         a, bus_rdata, exp);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int r;
        logic [31:0] d, exp;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            reset = (r == 0);
            bus_we = (r >= 1 && r <= 10);
            bus_addr = 2'($urandom_range(0, 3));
            d = $urandom;
            if (bus_addr == A_CTRL) d[2] = ($urandom_range(0, 3) != 0);
            if (bus_addr == A_PER) d = $urandom_range(0, 3);
            if (bus_addr == A_STAT) d[0] = ($urandom_range(0, 3) == 0);
            bus_wdata = d;
            led_rdata = $urandom;
            @(negedge clk);
            exp = m_read(bus_addr);
            checks++;
            if (led_we !== m_we || (m_we && led_wdata !== m_wd)
                || irq !== (m_pend & m_ien) || bus_rdata !== exp) begin
                errors++;
                $display("FAIL rand cyc %0d: we=%b wd=%h irq=%b rd=%h need %b %h %b %h",
                         n, led_we, led_wdata, irq, bus_rdata,
                         m_we, m_wd, m_pend & m_ien, exp);
            end
        end
        reset = 1'b0;
        bus_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_we = 1'b0;
        bus_addr = 2'd0;
        bus_wdata = 32'd0;
        led_rdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_static();
        test_rotl();
        test_blink();
        test_irq();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
